// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: shared state type, widths and clear value for the run-control sequencer
package prog_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_HOLD, S_RUN, S_DONE} prog_seq_state_t;
  localparam int PROG_SEQ_ADDR_W = 8;
  localparam int PROG_SEQ_PC_W = 32;
  localparam logic [PROG_SEQ_ADDR_W-1:0] PROG_SEQ_CLR_VALUE = 8'h00;
endpackage

// File: rtl/program_sequencer_if.sv
// program_sequencer_if: start/done protocol and datapath control signals of the sequencer
interface program_sequencer_if #(parameter int CYC_WIDTH = 16);
  import prog_seq_pkg::*;
  logic start;
  logic halt;
  logic done;
  logic busy;
  logic pc_rst;
  logic pc_en;
  logic core_en;
  logic rf_clr;
  logic dm_clr_en;
  logic [PROG_SEQ_ADDR_W-1:0] dm_clr_addr;
  logic [CYC_WIDTH-1:0] cycle_count;
  logic timeout;
  modport master (
    output start, halt,
    input done, busy, pc_rst, pc_en, core_en, rf_clr, dm_clr_en, dm_clr_addr, cycle_count, timeout
  );
  modport slave (
    input start, halt,
    output done, busy, pc_rst, pc_en, core_en, rf_clr, dm_clr_en, dm_clr_addr, cycle_count, timeout
  );
endinterface

// File: rtl/program_sequencer_sat_counter.sv
// sat_counter: up-counter with clear (priority), enable and saturation at all-ones
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: run-control FSM (clear/hold/run/done); watchdog timeout under PROG_SEQ_WATCHDOG_EN
module program_sequencer
  import prog_seq_pkg::*;
#(
  parameter int PC_WIDTH   = PROG_SEQ_PC_W,
  parameter int CLR_DEPTH  = 256,
  parameter int CYC_WIDTH  = 16,
  parameter int WDOG_LIMIT = 16'hFFFF
) (
  input logic clk,
  input logic reset,
  program_sequencer_if.slave bus
);
  localparam logic [PROG_SEQ_ADDR_W-1:0] CLR_LAST = PROG_SEQ_ADDR_W'(CLR_DEPTH - 1);
  prog_seq_state_t state, nxt;
  logic wdog;
  if (PC_WIDTH < 1 || CLR_DEPTH < 1 || CLR_DEPTH > 256 || WDOG_LIMIT < 1) begin : g_bad_cfg
    $error("program_sequencer: illegal parameter set");
  end
`ifdef PROG_SEQ_WATCHDOG_EN
  assign wdog = bus.cycle_count == CYC_WIDTH'(WDOG_LIMIT - 1);
  always_ff @(posedge clk)
    if (reset || nxt == S_CLEAR) bus.timeout <= 1'b0;
    else if (state == S_RUN && !bus.halt && wdog) bus.timeout <= 1'b1;
`else
  assign wdog = 1'b0;
  assign bus.timeout = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = bus.start ? S_CLEAR : S_IDLE;
      S_CLEAR: nxt = (bus.dm_clr_addr == CLR_LAST) ? S_HOLD : S_CLEAR;
      S_HOLD:  nxt = bus.start ? S_HOLD : S_RUN;
      S_RUN:   nxt = (bus.halt || wdog) ? S_DONE : S_RUN;
      S_DONE:  nxt = bus.start ? S_CLEAR : S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk)
    if (reset) begin
      state           <= S_IDLE;
      bus.dm_clr_addr <= '0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.pc_rst      <= 1'b0;
      bus.core_en     <= 1'b0;
      bus.rf_clr      <= 1'b0;
      bus.dm_clr_en   <= 1'b0;
    end else begin
      state           <= nxt;
      bus.dm_clr_addr <= (state == S_CLEAR && nxt == S_CLEAR) ? bus.dm_clr_addr + 1'b1 : '0;
      bus.done        <= nxt == S_DONE;
      bus.busy        <= nxt == S_CLEAR || nxt == S_HOLD || nxt == S_RUN;
      bus.pc_rst      <= nxt == S_CLEAR || nxt == S_HOLD;
      bus.core_en     <= nxt == S_RUN;
      bus.rf_clr      <= nxt == S_CLEAR;
      bus.dm_clr_en   <= nxt == S_CLEAR;
    end
  assign bus.pc_en = bus.core_en & ~bus.halt;
  sat_counter #(.W(CYC_WIDTH)) u_cyc (
    .clk (clk),
    .rst (reset),
    .clr (nxt == S_CLEAR),
    .en  (state == S_RUN),
    .q   (bus.cycle_count)
  );
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed checks of reset, clear/hold/run/done sequencing and watchdog
module tb_program_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  program_sequencer_if #(.CYC_WIDTH(16)) bus ();
  program_sequencer #(.CLR_DEPTH(4), .CYC_WIDTH(16), .WDOG_LIMIT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  // {done, busy, pc_rst, pc_en, core_en, rf_clr, dm_clr_en, timeout}
  wire [7:0] outs = {bus.done, bus.busy, bus.pc_rst, bus.pc_en, bus.core_en,
                     bus.rf_clr, bus.dm_clr_en, bus.timeout};
  localparam logic [7:0] O_IDLE = 8'h00, O_CLEAR = 8'h66, O_HOLD = 8'h60, O_RUN = 8'h58,
                         O_RUNH = 8'h48, O_DONE = 8'h80, O_TOUT = 8'h81;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.halt = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (outs !== O_IDLE || bus.cycle_count !== 16'd0 || bus.dm_clr_addr !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: outs=%h cc=%0d addr=%0d want outs=%h cc=0 addr=0",
                 i, outs, bus.cycle_count, bus.dm_clr_addr, O_IDLE);
      end
    end
  endtask

  task automatic test_clear_hold;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (i < 4 ? (outs !== O_CLEAR || bus.dm_clr_addr !== 8'(i)) : (outs !== O_HOLD)) begin
        n_bad++;
        $display("FAIL clear_hold[%0d]: outs=%h addr=%0d want outs=%h addr=%0d",
                 i, outs, bus.dm_clr_addr, i < 4 ? O_CLEAR : O_HOLD, i < 4 ? i : 0);
      end
    end
    bus.start = 1'b0;
    tick();
    n_cmp++;
    if (outs !== O_RUN || bus.cycle_count !== 16'd0) begin
      n_bad++;
      $display("FAIL run_entry: outs=%h cc=%0d want outs=%h cc=0", outs, bus.cycle_count, O_RUN);
    end
  endtask

  task automatic test_halt;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) tick();
      bus.halt = (k == 7);
      #1;
      n_cmp++;
      if (outs !== (k == 7 ? O_RUNH : O_RUN) || bus.cycle_count !== 16'(k - 1)) begin
        n_bad++;
        $display("FAIL run_cycle[%0d]: outs=%h cc=%0d want outs=%h cc=%0d",
                 k, outs, bus.cycle_count, k == 7 ? O_RUNH : O_RUN, k - 1);
      end
    end
    tick();
    bus.halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (outs !== O_DONE || bus.cycle_count !== 16'd7) begin
        n_bad++;
        $display("FAIL done_hold[%0d]: outs=%h cc=%0d want outs=%h cc=7", i, outs, bus.cycle_count, O_DONE);
      end
      tick();
    end
  endtask

  task automatic test_short_start_rerun;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (outs !== O_CLEAR || bus.cycle_count !== 16'd0 || bus.dm_clr_addr !== 8'd0) begin
      n_bad++;
      $display("FAIL restart: outs=%h cc=%0d addr=%0d want outs=%h cc=0 addr=0",
               outs, bus.cycle_count, bus.dm_clr_addr, O_CLEAR);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_cmp++;
      if (outs !== O_CLEAR || bus.dm_clr_addr !== 8'(i)) begin
        n_bad++;
        $display("FAIL short_clear[%0d]: outs=%h addr=%0d want outs=%h addr=%0d",
                 i, outs, bus.dm_clr_addr, O_CLEAR, i);
      end
    end
    tick();
    n_cmp++;
    if (outs !== O_HOLD) begin
      n_bad++;
      $display("FAIL short_hold: outs=%h want %h", outs, O_HOLD);
    end
    tick();
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL short_run: outs=%h want %h", outs, O_RUN);
    end
    tick(); tick();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    n_cmp++;
    if (outs !== O_DONE || bus.cycle_count !== 16'd3) begin
      n_bad++;
      $display("FAIL rerun_done: outs=%h cc=%0d want outs=%h cc=3", outs, bus.cycle_count, O_DONE);
    end
  endtask

  task automatic test_reset_mid_run;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    n_cmp++;
    if (outs !== O_RUN || bus.cycle_count !== 16'd2) begin
      n_bad++;
      $display("FAIL run_cycle3: outs=%h cc=%0d want outs=%h cc=2", outs, bus.cycle_count, O_RUN);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (outs !== O_IDLE || bus.cycle_count !== 16'd0 || bus.dm_clr_addr !== 8'd0) begin
      n_bad++;
      $display("FAIL mid_run_reset: outs=%h cc=%0d addr=%0d want outs=00 cc=0 addr=0",
               outs, bus.cycle_count, bus.dm_clr_addr);
    end
  endtask

  task automatic test_watchdog;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int k = 1; k <= 10; k++) begin
      n_cmp++;
      if (outs !== O_RUN) begin
        n_bad++;
        $display("FAIL wdog_run[%0d]: outs=%h want %h", k, outs, O_RUN);
      end
      tick();
    end
`ifdef PROG_SEQ_WATCHDOG_EN
    n_cmp++;
    if (outs !== O_TOUT || bus.cycle_count !== 16'd10) begin
      n_bad++;
      $display("FAIL wdog_fire: outs=%h cc=%0d want outs=%h cc=10", outs, bus.cycle_count, O_TOUT);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (outs !== O_CLEAR) begin
      n_bad++;
      $display("FAIL wdog_clear: outs=%h want %h", outs, O_CLEAR);
    end
`else
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (outs !== O_RUN || bus.cycle_count !== 16'd30) begin
      n_bad++;
      $display("FAIL no_wdog: outs=%h cc=%0d want outs=%h cc=30", outs, bus.cycle_count, O_RUN);
    end
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    n_cmp++;
    if (outs !== O_DONE || bus.cycle_count !== 16'd31) begin
      n_bad++;
      $display("FAIL no_wdog_done: outs=%h cc=%0d want outs=%h cc=31", outs, bus.cycle_count, O_DONE);
    end
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.halt = 1'b0;
    test_reset();
    test_clear_hold();
    test_halt();
    test_short_start_rerun();
    test_reset_mid_run();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
